// File: rtl/mlm_ecc_pkg.sv
// Shared types and Hamming helpers for the 16-bit/5-parity ECC checker.
// Bit 0 of data and parity vectors is d00/p00 (leftmost in a literal).
package mlm_ecc_pkg;

  localparam int DATA_W = 16;
  localparam int PAR_W  = 5;

  typedef logic [4:0]        syn_t;
  typedef logic [0:DATA_W-1] data_t;
  typedef logic [0:PAR_W-1]  par_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
    logic       par_only;
  } dec_t;

  // Data-bit coverage of each parity bit, in d00..d15 order.
  localparam data_t PAR_MASK [PAR_W] = '{
    16'hDAB5,
    16'hB66C,
    16'h71E3,
    16'h0FE0,
    16'h001F
  };

  function automatic par_t calc_par(input data_t d);
    par_t p;
    p = '0;
    for (int i = 0; i < PAR_W; i++) begin
      p[i] = ^(d & PAR_MASK[i]);
    end
    return p;
  endfunction

  // hit=1 for any correctable syndrome; par_only=1 when the flipped bit is a parity bit.
  function automatic dec_t syn2idx(input syn_t s);
    dec_t r;
    r = '0;
    case (s)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: r = '{hit: 1'b1, idx: 4'd0, par_only: 1'b1};
      5'd3:  r = '{hit: 1'b1, idx: 4'd0,  par_only: 1'b0};
      5'd5:  r = '{hit: 1'b1, idx: 4'd1,  par_only: 1'b0};
      5'd6:  r = '{hit: 1'b1, idx: 4'd2,  par_only: 1'b0};
      5'd7:  r = '{hit: 1'b1, idx: 4'd3,  par_only: 1'b0};
      5'd9:  r = '{hit: 1'b1, idx: 4'd4,  par_only: 1'b0};
      5'd10: r = '{hit: 1'b1, idx: 4'd5,  par_only: 1'b0};
      5'd11: r = '{hit: 1'b1, idx: 4'd6,  par_only: 1'b0};
      5'd12: r = '{hit: 1'b1, idx: 4'd7,  par_only: 1'b0};
      5'd13: r = '{hit: 1'b1, idx: 4'd8,  par_only: 1'b0};
      5'd14: r = '{hit: 1'b1, idx: 4'd9,  par_only: 1'b0};
      5'd15: r = '{hit: 1'b1, idx: 4'd10, par_only: 1'b0};
      5'd17: r = '{hit: 1'b1, idx: 4'd11, par_only: 1'b0};
      5'd18: r = '{hit: 1'b1, idx: 4'd12, par_only: 1'b0};
      5'd19: r = '{hit: 1'b1, idx: 4'd13, par_only: 1'b0};
      5'd20: r = '{hit: 1'b1, idx: 4'd14, par_only: 1'b0};
      5'd21: r = '{hit: 1'b1, idx: 4'd15, par_only: 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mlm_ecc_chk_stage.sv
// Generic valid/ready pipeline register; accepts whenever empty or draining.
module mlm_ecc_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Payload only loads on a real transfer so it stays stable during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/mlm_ecc_chk.sv
// Hamming 16/5 checker: syndrome in stage 1, correction and flags in stage 2,
// plus saturating error counters and a sticky error flag.
module mlm_ecc_chk
  import mlm_ecc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit PASS_UNCORR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] in_d,
  input  logic [0:PAR_W-1]  in_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_d,
  output logic              out_corr,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              err_sticky
);

  localparam int S1_W = DATA_W + 5;
  localparam int S2_W = DATA_W + 2;

  syn_t            inSyn;
  par_t            recPar;
  logic [S1_W-1:0] s1Data;
  logic            s1Valid;
  logic            s2Ready;
  data_t           s1D;
  syn_t            s1Syn;
  dec_t            dec;
  data_t           corrD;
  logic            s1Uncorr;
  logic            s1Drop;
  logic            s2ValidIn;
  logic [S2_W-1:0] s2Data;

  always_comb begin
    recPar = calc_par(in_d);
    inSyn  = '0;
    for (int i = 0; i < PAR_W; i++) begin
      inSyn[i] = recPar[i] ^ in_p[i];
    end
  end

  mlm_ecc_stage #(.W(S1_W)) uStage1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  ({in_d, inSyn}),
    .valid_o (s1Valid),
    .ready_i (s2Ready),
    .data_o  (s1Data)
  );

  assign s1D   = s1Data[S1_W-1:5];
  assign s1Syn = s1Data[4:0];

  // Data syndromes flip one bit; parity-only and uncorrectable ones pass data through.
  always_comb begin
    dec      = syn2idx(s1Syn);
    corrD    = s1D;
    s1Uncorr = (s1Syn != '0) && !dec.hit;
    if (dec.hit && !dec.par_only) begin
      corrD[dec.idx] = !s1D[dec.idx];
    end
  end

  assign s1Drop    = !PASS_UNCORR && s1Uncorr;
  assign s2ValidIn = s1Valid && !s1Drop;

  mlm_ecc_stage #(.W(S2_W)) uStage2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s2ValidIn),
    .ready_o (s2Ready),
    .data_i  ({corrD, dec.hit, s1Uncorr}),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (s2Data)
  );

  assign out_d      = s2Data[S2_W-1:2];
  assign out_corr   = s2Data[1];
  assign out_uncorr = s2Data[0];

  logic             outXfer;
  logic             dropEvt;
  logic             corrInc;
  logic             uncorrInc;
  logic [CNT_W-1:0] corrCnt_q, corrCnt_d;
  logic [CNT_W-1:0] uncorrCnt_q, uncorrCnt_d;
  logic             sticky_q, sticky_d;

  assign outXfer   = out_valid && out_ready;
  assign dropEvt   = s1Valid && s2Ready && s1Drop;
  assign corrInc   = outXfer && out_corr;
  assign uncorrInc = (outXfer && out_uncorr) || dropEvt;

  // Clear takes priority over any same-cycle increment or sticky set.
  always_comb begin
    corrCnt_d   = corrCnt_q;
    uncorrCnt_d = uncorrCnt_q;
    sticky_d    = sticky_q;
    if (cnt_clr) begin
      corrCnt_d   = '0;
      uncorrCnt_d = '0;
      sticky_d    = 1'b0;
    end else begin
      if (corrInc && (corrCnt_q != '1)) begin
        corrCnt_d = corrCnt_q + CNT_W'(1);
      end
      if (uncorrInc && (uncorrCnt_q != '1)) begin
        uncorrCnt_d = uncorrCnt_q + CNT_W'(1);
      end
      if (corrInc || uncorrInc) begin
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corrCnt_q   <= '0;
      uncorrCnt_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      corrCnt_q   <= corrCnt_d;
      uncorrCnt_q <= uncorrCnt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign corr_cnt   = corrCnt_q;
  assign uncorr_cnt = uncorrCnt_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_mlm_ecc_chk.sv
// Directed bench for mlm_ecc_chk: main instance plus a drop-mode and a 2-bit-counter instance.
module tb_mlm_ecc_chk;

  logic        clk;
  logic        rst_n;
  logic        cnt_clr;
  logic        out_ready;
  logic [0:15] in_d;
  logic [0:4]  in_p;

  logic        inValid, inReady, outValid, outCorr, outUncorr, errSticky;
  logic [0:15] outD;
  logic [15:0] corrCnt, uncorrCnt;

  logic        validDrop, dropInReady, dropOutValid, dropCorr, dropUncorr, dropSticky;
  logic [0:15] dropOutD;
  logic [15:0] dropCorrCnt, dropUncorrCnt;

  logic        validSat, satInReady, satOutValid, satCorr, satUncorr, satSticky;
  logic [0:15] satOutD;
  logic [1:0]  satCorrCnt, satUncorrCnt;

  int passCount  = 0;
  int checkCount = 0;

  mlm_ecc_chk #(.CNT_W(16), .PASS_UNCORR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .in_d(in_d), .in_p(in_p), .out_valid(outValid), .out_ready(out_ready),
    .out_d(outD), .out_corr(outCorr), .out_uncorr(outUncorr), .cnt_clr(cnt_clr),
    .corr_cnt(corrCnt), .uncorr_cnt(uncorrCnt), .err_sticky(errSticky)
  );

  mlm_ecc_chk #(.CNT_W(16), .PASS_UNCORR(1'b0)) dutDrop (
    .clk(clk), .rst_n(rst_n), .in_valid(validDrop), .in_ready(dropInReady),
    .in_d(in_d), .in_p(in_p), .out_valid(dropOutValid), .out_ready(out_ready),
    .out_d(dropOutD), .out_corr(dropCorr), .out_uncorr(dropUncorr), .cnt_clr(cnt_clr),
    .corr_cnt(dropCorrCnt), .uncorr_cnt(dropUncorrCnt), .err_sticky(dropSticky)
  );

  mlm_ecc_chk #(.CNT_W(2), .PASS_UNCORR(1'b1)) dutSat (
    .clk(clk), .rst_n(rst_n), .in_valid(validSat), .in_ready(satInReady),
    .in_d(in_d), .in_p(in_p), .out_valid(satOutValid), .out_ready(out_ready),
    .out_d(satOutD), .out_corr(satCorr), .out_uncorr(satUncorr), .cnt_clr(cnt_clr),
    .corr_cnt(satCorrCnt), .uncorr_cnt(satUncorrCnt), .err_sticky(satSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  // One word through the main instance with out_ready high; checks latency and result.
  task automatic applyStimulus(input string tag, input logic [0:15] d, input logic [0:4] p,
                               input logic [0:15] expD, input logic expCorr,
                               input logic expUncorr, input logic clrAtOut);
    @(negedge clk);
    checkOutput({tag, ":inReady"}, inReady, 1);
    inValid = 1'b1;
    in_d    = d;
    in_p    = p;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput({tag, ":early"}, outValid, 0);
    @(negedge clk);
    checkOutput({tag, ":outValid"}, outValid, 1);
    checkOutput({tag, ":outD"}, outD, expD);
    checkOutput({tag, ":corr"}, outCorr, expCorr);
    checkOutput({tag, ":uncorr"}, outUncorr, expUncorr);
    cnt_clr = clrAtOut;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  logic [0:15] bpIn [4];
  logic [0:4]  bpPar [4];
  logic [0:15] bpExp [4];
  logic [0:15] heldD;
  logic        held, accept, sawValid;
  int          wIdx, rIdx;

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    in_d = '0; in_p = '0; inValid = 1'b0; validDrop = 1'b0; validSat = 1'b0;
    bpIn[0] = 16'hA5C3; bpPar[0] = 5'b10000; bpExp[0] = 16'hA5C3;
    bpIn[1] = 16'h0100; bpPar[1] = 5'b00000; bpExp[1] = 16'h0000;
    bpIn[2] = 16'hFFFF; bpPar[2] = 5'b01111; bpExp[2] = 16'hFFFF;
    bpIn[3] = 16'h00FE; bpPar[3] = 5'b10111; bpExp[3] = 16'h00FF;

    repeat (2) @(negedge clk);
    checkOutput("rst:outValid", outValid, 0);
    checkOutput("rst:outD", outD, 0);
    rst_n = 1'b1;
    checkOutput("rst:inReady", inReady, 1);
    checkOutput("rst:corrCnt", corrCnt, 0);
    checkOutput("rst:uncorrCnt", uncorrCnt, 0);
    checkOutput("rst:sticky", errSticky, 0);

    applyStimulus("clean", 16'hA5C3, 5'b10000, 16'hA5C3, 0, 0, 0);
    checkOutput("clean:corrCnt", corrCnt, 0);
    checkOutput("clean:uncorrCnt", uncorrCnt, 0);
    checkOutput("clean:sticky", errSticky, 0);

    applyStimulus("d07", 16'h0100, 5'b00000, 16'h0000, 1, 0, 0);
    checkOutput("d07:corrCnt", corrCnt, 1);
    checkOutput("d07:sticky", errSticky, 1);
    applyStimulus("d15", 16'hA5C2, 5'b10000, 16'hA5C3, 1, 0, 0);
    applyStimulus("d00", 16'h8000, 5'b00000, 16'h0000, 1, 0, 0);
    applyStimulus("p04", 16'h0000, 5'b00001, 16'h0000, 1, 0, 0);
    applyStimulus("p00", 16'h0000, 5'b10000, 16'h0000, 1, 0, 0);
    checkOutput("corr:corrCnt", corrCnt, 5);
    applyStimulus("s22", 16'h0000, 5'b01101, 16'h0000, 0, 1, 0);
    applyStimulus("s31", 16'hA5C3, 5'b01111, 16'hA5C3, 0, 1, 0);
    checkOutput("uncorr:uncorrCnt", uncorrCnt, 2);
    checkOutput("uncorr:corrCnt", corrCnt, 5);

    applyStimulus("clr", 16'h0100, 5'b00000, 16'h0000, 1, 0, 1);
    checkOutput("clr:corrCnt", corrCnt, 0);
    checkOutput("clr:uncorrCnt", uncorrCnt, 0);
    checkOutput("clr:sticky", errSticky, 0);

    // Backpressure: out_ready low for the first three cycles.
    wIdx = 0; rIdx = 0; held = 1'b0; heldD = '0;
    @(negedge clk);
    inValid = 1'b1; in_d = bpIn[0]; in_p = bpPar[0];
    for (int cyc = 0; cyc < 40 && rIdx < 4; cyc++) begin
      out_ready = (cyc >= 3);
      #1;
      if (cyc == 2) begin
        checkOutput("bp:inReadyDrop", inReady, 0);
        checkOutput("bp:accepted", wIdx, 2);
      end
      if (held) begin
        checkOutput("bp:stableValid", outValid, 1);
        checkOutput("bp:stableD", outD, heldD);
      end
      if (outValid && out_ready) begin
        checkOutput("bp:order", outD, bpExp[rIdx]);
        rIdx++;
      end
      held   = outValid && !out_ready;
      heldD  = outD;
      accept = inValid && inReady;
      @(posedge clk);
      #1;
      if (accept) begin
        wIdx++;
        if (wIdx < 4) begin
          in_d = bpIn[wIdx];
          in_p = bpPar[wIdx];
        end else begin
          inValid = 1'b0;
        end
      end
      @(negedge clk);
    end
    inValid   = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp:delivered", rIdx, 4);
    checkOutput("bp:corrCnt", corrCnt, 2);

    // Drop mode: uncorrectable word is counted but never presented.
    @(negedge clk);
    validDrop = 1'b1; in_d = 16'h0000; in_p = 5'b01101;
    @(negedge clk);
    validDrop = 1'b0;
    sawValid  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (dropOutValid) sawValid = 1'b1;
    end
    checkOutput("drop:noOut", sawValid, 0);
    checkOutput("drop:uncorrCnt", dropUncorrCnt, 1);
    checkOutput("drop:sticky", dropSticky, 1);
    checkOutput("drop:inReady", dropInReady, 1);
    validDrop = 1'b1; in_d = 16'hA5C3; in_p = 5'b10000;
    @(negedge clk);
    validDrop = 1'b0;
    @(negedge clk);
    checkOutput("drop:cleanValid", dropOutValid, 1);
    checkOutput("drop:cleanD", dropOutD, 16'hA5C3);

    // Saturation with a 2-bit counter.
    repeat (5) begin
      @(negedge clk);
      validSat = 1'b1; in_d = 16'h0100; in_p = 5'b00000;
      @(negedge clk);
      validSat = 1'b0;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    checkOutput("sat:corrCnt", satCorrCnt, 3);
    checkOutput("sat:uncorrCnt", satUncorrCnt, 0);
    checkOutput("sat:sticky", satSticky, 1);

    // Reset with two words in flight.
    @(negedge clk);
    inValid = 1'b1; in_d = 16'hA5C3; in_p = 5'b10000;
    @(negedge clk);
    in_d = 16'hFFFF; in_p = 5'b01111;
    @(negedge clk);
    inValid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkOutput("midRst:outValid", outValid, 0);
    checkOutput("midRst:outD", outD, 0);
    checkOutput("midRst:corrCnt", corrCnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midRst:inReady", inReady, 1);
    sawValid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("midRst:noOut", sawValid, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mlm_ecc_chk.md
Name: mlm_ecc_chk

Overview:
Downstream consumer of the 16-bit/5-parity Hamming generator in the multi-level-merge design. Accepts a data word plus its stored parity over a valid/ready handshake. Recomputes parity and forms the syndrome, then corrects any single-bit error. Emits the corrected word with error flags through a 2-stage pipeline, and keeps saturating error counters for coverage/merge tests.

Parameters:
CNT_W, 16, width of each saturating error counter
PASS_UNCORR, 1, 1: uncorrectable words are forwarded with err_uncorr set; 0: they are dropped (counted, never presented on out_*)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept input this cycle
in_d  input  [0:15]  received data bits d00..d15
in_p  input  [0:4]  received parity bits p00..p04
out_valid  output  1  corrected word valid
out_ready  input  1  downstream accepts output
out_d  output  [0:15]  corrected data
out_corr  output  1  single-bit error corrected (data or parity bit)
out_uncorr  output  1  syndrome not mappable; out_d = in_d unmodified
cnt_clr  input  1  synchronous clear of counters and sticky flag
corr_cnt  output  CNT_W  corrected-word count, saturating
uncorr_cnt  output  CNT_W  uncorrectable-word count, saturating
err_sticky  output  1  set on any nonzero syndrome, held until cnt_clr

Behaviour:
- Reset (rst_n low, async): both stage valids = 0, out_valid = 0, out_d = 0, out_corr = 0, out_uncorr = 0, counters = 0, err_sticky = 0. Words in flight are discarded. in_ready = 1 in the first cycle after release.
- Parity equations (XOR of data bits):
  - p00 = {0,1,3,4,6,8,10,11,13,15}
  - p01 = {0,2,3,5,6,9,10,12,13}
  - p02 = {1,2,3,7,8,9,10,14,15}
  - p03 = {4..10}
  - p04 = {11..15}
- Syndrome s[4:0] = recomputed XOR in_p, weights p00=1, p01=2, p02=4, p03=8, p04=16.
- Stage 1: registers in_d and s on an accepted transfer (in_valid && in_ready).
- Stage 2: registers corrected data and flags. Latency is exactly 2 cycles from acceptance to out_valid with no stall.
- Syndrome decode:
  - s=0: no error.
  - s in {1,2,4,8,16}: parity-bit error; data unchanged, out_corr = 1.
  - Data positions, s -> d index: 3->0, 5->1, 6->2, 7->3, 9->4, 10->5, 11->6, 12->7, 13->8, 14->9, 15->10, 17->11, 18->12, 19->13, 20->14, 21->15. The mapped bit is flipped and out_corr = 1.
  - s in 22..31: out_uncorr = 1, data unchanged.
- Handshake:
  - A stage advances when its downstream is empty or accepting.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational and must not depend on in_valid.
  - out_d/out_corr/out_uncorr are held stable while out_valid && !out_ready.
  - Full throughput: one word per cycle when out_ready stays high.
- Dropped word (PASS_UNCORR=0, uncorrectable): stage 2 does not become valid and in_ready is unaffected.
- Counters:
  - corr_cnt increments on an output transfer with out_corr.
  - uncorr_cnt increments on an output transfer with out_uncorr, or on the drop event when PASS_UNCORR=0.
  - Both saturate at all-ones.
  - cnt_clr in the same cycle as an increment: clear wins, result 0.
- err_sticky sets on the same events as the counters. Set and cnt_clr in the same cycle: clear wins.

Decomposition:
- Package mlm_ecc_pkg:
  - localparams DATA_W=16, PAR_W=5.
  - typedef syn_t (5-bit).
  - function calc_par(d) returning the 5 parity bits.
  - function syn2idx(s) returning {hit, idx[3:0], par_only}.
- One sub-module, mlm_ecc_stage: a generic valid/ready pipeline register. It is instantiated twice, with payload width as a parameter.
- The decode and counters stay in the top level.

Test Plan:
- Clean stream: in_d=16'hA5C3 with matching parity, out_ready=1 -> out_d=16'hA5C3 two cycles later, flags 0, counters 0.
- Data flip: in_d = correct word 16'h0000 with bit d07 set, in_p=0 -> s=12, out_d=16'h0000, out_corr=1, corr_cnt=1, err_sticky=1.
- Parity flip: in_d=16'h0000, in_p=5'b00001 (p04) -> s=16, out_d=0, out_corr=1.
- Uncorrectable: in_d=16'h0000, in_p=5'b10110 (p00, p02, p03 set, s=13?) replaced by in_p with s=22 -> out_uncorr=1; with PASS_UNCORR=0 no out_valid, uncorr_cnt=1.
- Backpressure: 4 back-to-back words with out_ready low for 3 cycles -> in_ready drops after 2 accepted, outputs stable, all 4 delivered in order.
- Saturation/clear, reset mid-flight:
  - CNT_W=2 with 5 correctable words -> corr_cnt=3.
  - cnt_clr coinciding with a correction -> 0.
  - rst_n low with 2 words in flight -> out_valid=0, nothing emitted after release.
